// File: rtl/spr_cmd_ctrl.sv
// rtl/spr_cmd_ctrl.sv - serial sprite command receiver with vblank-gated write scheduler
module spr_cmd_ctrl #(
  parameter int DATA_W      = 12,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        spr_clk,
  input  logic                        spr_cmd,
  input  logic                        spr_ser,
  input  logic                        vblank,
  input  logic                        wr_ready,
  output logic                        wr_valid,
  output logic [3:0]                  wr_cmd,
  output logic [DATA_W-1:0]           wr_data,
  output logic [3:0]                  last_cmd,
  output logic                        frame_err,
  output logic                        fifo_ovf,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int FRAME_BITS = 4 + DATA_W;
  localparam int CNT_W      = $clog2(FRAME_BITS + 2);
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int LVL_W      = PTR_W + 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);
  localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(FIFO_DEPTH);

  typedef enum logic {RX_IDLE, RX_SHIFT} rx_state_t;
  typedef enum logic {AP_IDLE, AP_APPLY} ap_state_t;

  // ---------------------------------------------------------------
  // Input synchronisers and edge detection
  // ---------------------------------------------------------------
  logic [SYNC_STAGES-1:0] clk_sync, cmd_sync, ser_sync;
  logic                   clk_dly, cmd_dly;
  // valid_sh fills with ones after reset; its top bit marks the point
  // where the delay flops hold real pin samples, so a pin already high
  // when reset is released is never mistaken for a rising edge.
  logic [SYNC_STAGES:0]   valid_sh;

  logic clk_s, cmd_s, ser_s, sync_ok;
  logic clk_rise, cmd_rise, cmd_fall;

  // Shift each async pin through its synchroniser chain plus one delay flop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync <= '0;
      cmd_sync <= '0;
      ser_sync <= '0;
      clk_dly  <= 1'b0;
      cmd_dly  <= 1'b0;
      valid_sh <= '0;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], spr_clk};
      cmd_sync <= {cmd_sync[SYNC_STAGES-2:0], spr_cmd};
      ser_sync <= {ser_sync[SYNC_STAGES-2:0], spr_ser};
      clk_dly  <= clk_sync[SYNC_STAGES-1];
      cmd_dly  <= cmd_sync[SYNC_STAGES-1];
      valid_sh <= {valid_sh[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign clk_s    = clk_sync[SYNC_STAGES-1];
  assign cmd_s    = cmd_sync[SYNC_STAGES-1];
  assign ser_s    = ser_sync[SYNC_STAGES-1];
  assign sync_ok  = valid_sh[SYNC_STAGES];
  assign clk_rise = sync_ok &  clk_s & ~clk_dly;
  assign cmd_rise = sync_ok &  cmd_s & ~cmd_dly;
  assign cmd_fall = sync_ok & ~cmd_s &  cmd_dly;

  // ---------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------
  rx_state_t             rx_state, rx_next;
  logic [FRAME_BITS-1:0] sr;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  frame_end;
  logic                  frame_ok;

  // Receiver state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rx_state <= RX_IDLE;
    else       rx_state <= rx_next;
  end

  // Receiver next state: frame opens on cmd rise, closes on cmd fall
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (cmd_rise) rx_next = RX_SHIFT;
      RX_SHIFT: if (cmd_fall) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  // Shift register and saturating bit counter; frame_end marks the cycle after the fall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr        <= '0;
      bit_cnt   <= '0;
      frame_end <= 1'b0;
    end else begin
      frame_end <= (rx_state == RX_SHIFT) && cmd_fall;
      if ((rx_state == RX_IDLE) && cmd_rise) begin
        sr      <= '0;
        bit_cnt <= '0;
      end else if ((rx_state == RX_SHIFT) && clk_rise && cmd_s) begin
        sr <= {sr[FRAME_BITS-2:0], ser_s};
        if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

  assign frame_ok  = frame_end && (bit_cnt == CNT_FULL);
  assign frame_err = frame_end && !frame_ok;

  // Remember the command nibble of every well-formed frame, queued or dropped
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         last_cmd <= 4'h0;
    else if (frame_ok) last_cmd <= sr[FRAME_BITS-1 -: 4];
  end

  // ---------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------
  logic [FRAME_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic                  fifo_full, fifo_empty, pop, push_acc;
  logic [FRAME_BITS-1:0] head;

  assign fifo_full  = (fifo_level == LVL_MAX);
  assign fifo_empty = (fifo_level == '0);
  assign pop        = wr_valid && wr_ready;
  assign push_acc   = frame_ok && (!fifo_full || pop);
  assign fifo_ovf   = frame_ok && fifo_full && !pop;
  assign head       = mem[rd_ptr];

  // Storage array; contents are only observed through wr_valid
  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr] <= sr;
  end

  // Pointers wrap naturally since depth is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop)      rd_ptr <= rd_ptr + 1'b1;
      if (push_acc && !pop)      fifo_level <= fifo_level + 1'b1;
      else if (!push_acc && pop) fifo_level <= fifo_level - 1'b1;
    end
  end

  // ---------------------------------------------------------------
  // Apply scheduler
  // ---------------------------------------------------------------
  ap_state_t ap_state, ap_next;

  // Apply state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ap_state <= AP_IDLE;
    else       ap_state <= ap_next;
  end

  // Apply next state and write request; an issued request is held until taken
  always_comb begin
    ap_next  = ap_state;
    wr_valid = 1'b0;
    case (ap_state)
      AP_IDLE: begin
        if (vblank && !fifo_empty) ap_next = AP_APPLY;
      end
      AP_APPLY: begin
        wr_valid = !fifo_empty;
        if (fifo_empty || (!vblank && pop)) ap_next = AP_IDLE;
      end
      default: ap_next = AP_IDLE;
    endcase
  end

  assign wr_cmd  = wr_valid ? head[FRAME_BITS-1 -: 4] : 4'h0;
  assign wr_data = wr_valid ? head[DATA_W-1:0] : '0;

endmodule

// File: tb/tb_spr_cmd_ctrl.sv
// tb/tb_spr_cmd_ctrl.sv - directed self-checking bench for spr_cmd_ctrl
module tb_spr_cmd_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        spr_clk, spr_cmd, spr_ser, vblank, wr_ready;
  logic        wr_valid;
  logic [3:0]  wr_cmd;
  logic [11:0] wr_data;
  logic [3:0]  last_cmd;
  logic        frame_err, fifo_ovf;
  logic [2:0]  fifo_level;

  int tests_run    = 0;
  int tests_failed = 0;

  int          cyc    = 0;
  int          err_cnt = 0;
  int          ovf_cnt = 0;
  int          hs_n   = 0;
  logic [3:0]  hs_cmd  [64];
  logic [11:0] hs_data [64];
  int          hs_cyc  [64];

  spr_cmd_ctrl #(.DATA_W(12), .FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .spr_clk    (spr_clk),
    .spr_cmd    (spr_cmd),
    .spr_ser    (spr_ser),
    .vblank     (vblank),
    .wr_ready   (wr_ready),
    .wr_valid   (wr_valid),
    .wr_cmd     (wr_cmd),
    .wr_data    (wr_data),
    .last_cmd   (last_cmd),
    .frame_err  (frame_err),
    .fifo_ovf   (fifo_ovf),
    .fifo_level (fifo_level)
  );

  always #10 clk = ~clk;

  // Count pulses and record every accepted write, sampled mid-cycle
  always @(negedge clk) begin
    cyc++;
    if (frame_err) err_cnt++;
    if (fifo_ovf)  ovf_cnt++;
    if (wr_valid && wr_ready && hs_n < 64) begin
      hs_cmd[hs_n]  = wr_cmd;
      hs_data[hs_n] = wr_data;
      hs_cyc[hs_n]  = cyc;
      hs_n++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    spr_ser = b;
    tick(3);
    spr_clk = 1'b1;
    tick(3);
    spr_clk = 1'b0;
  endtask

  task automatic send_bits(input int n, input logic [31:0] v);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_frame(input int n, input logic [31:0] v);
    spr_cmd = 1'b1;
    tick(4);
    send_bits(n, v);
    tick(4);
    spr_cmd = 1'b0;
    tick(8);
  endtask

  int base;
  int e0;

  initial begin
    reset = 1'b1; spr_clk = 0; spr_cmd = 0; spr_ser = 0; vblank = 0; wr_ready = 0;
    tick(3);
    reset = 1'b0;
    tick(2);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_wr_cmd", wr_cmd, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_last_cmd", last_cmd, 0);
    check("rst_level", fifo_level, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_fifo_ovf", fifo_ovf, 0);

    // Single good frame held back by vblank
    send_frame(16, 32'h3ABC);
    check("f1_level", fifo_level, 1);
    check("f1_last_cmd", last_cmd, 3);
    check("f1_wr_valid", wr_valid, 0);
    wr_ready = 1'b1;
    tick(5);
    check("f1_no_write_outside_vblank", hs_n, 0);
    vblank = 1'b1;
    tick(8);
    check("f1_writes", hs_n, 1);
    check("f1_wr_cmd", hs_cmd[0], 4'h3);
    check("f1_wr_data", hs_data[0], 12'hABC);
    check("f1_level_after", fifo_level, 0);
    check("f1_wr_valid_after", wr_valid, 0);
    vblank = 1'b0;
    tick(2);

    // Short and long frames are rejected
    send_frame(15, 32'h1234);
    check("short_err", err_cnt, 1);
    check("short_level", fifo_level, 0);
    check("short_last_cmd", last_cmd, 3);
    send_frame(17, 32'h15123);
    check("long_err", err_cnt, 2);
    check("long_level", fifo_level, 0);
    check("long_last_cmd", last_cmd, 3);
    check("bad_no_ovf", ovf_cnt, 0);

    // Overflow: five frames into a four-deep FIFO
    send_frame(16, 32'h1111);
    send_frame(16, 32'h2222);
    send_frame(16, 32'h3333);
    send_frame(16, 32'h4444);
    check("full_level", fifo_level, 4);
    check("full_no_ovf_yet", ovf_cnt, 0);
    send_frame(16, 32'h5555);
    check("ovf_pulse", ovf_cnt, 1);
    check("ovf_level", fifo_level, 4);
    check("ovf_last_cmd", last_cmd, 5);
    base = hs_n;
    vblank = 1'b1;
    tick(10);
    check("drain_count", hs_n - base, 4);
    check("drain_cmd0", {hs_cmd[base], hs_data[base]}, 16'h1111);
    check("drain_cmd1", {hs_cmd[base+1], hs_data[base+1]}, 16'h2222);
    check("drain_cmd2", {hs_cmd[base+2], hs_data[base+2]}, 16'h3333);
    check("drain_cmd3", {hs_cmd[base+3], hs_data[base+3]}, 16'h4444);
    check("drain_back_to_back", hs_cyc[base+3] - hs_cyc[base], 3);
    check("drain_level", fifo_level, 0);
    vblank = 1'b0;
    tick(2);

    // Outstanding write survives vblank falling
    wr_ready = 1'b0;
    send_frame(16, 32'h66A1);
    send_frame(16, 32'h77B2);
    check("hold_level", fifo_level, 2);
    vblank = 1'b1;
    tick(5);
    check("hold_valid_vb", wr_valid, 1);
    check("hold_data_vb", {wr_cmd, wr_data}, 16'h66A1);
    vblank = 1'b0;
    tick(5);
    check("hold_valid_novb", wr_valid, 1);
    check("hold_data_novb", {wr_cmd, wr_data}, 16'h66A1);
    base = hs_n;
    wr_ready = 1'b1;
    tick(12);
    check("hold_one_write", hs_n - base, 1);
    check("hold_write_data", {hs_cmd[base], hs_data[base]}, 16'h66A1);
    check("hold_level_after", fifo_level, 1);
    check("hold_idle_valid", wr_valid, 0);
    vblank = 1'b1;
    tick(6);
    check("hold_next_vb_write", hs_n - base, 2);
    check("hold_next_data", {hs_cmd[base+1], hs_data[base+1]}, 16'h77B2);
    vblank = 1'b0;
    tick(2);

    // Reset mid-frame with entries queued
    send_frame(16, 32'h8123);
    send_frame(16, 32'h8456);
    check("pre_rst_level", fifo_level, 2);
    spr_cmd = 1'b1;
    tick(4);
    send_bits(8, 32'hA5);
    reset = 1'b1;
    #1;
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_last_cmd", last_cmd, 0);
    tick(2);
    reset = 1'b0;
    tick(1);
    check("post_rst_level", fifo_level, 0);
    check("post_rst_last_cmd", last_cmd, 0);
    check("post_rst_out", {wr_valid, wr_cmd, wr_data, frame_err, fifo_ovf}, 0);
    e0 = err_cnt;
    send_bits(8, 32'h5A);
    tick(4);
    spr_cmd = 1'b0;
    tick(8);
    check("post_rst_ignore_level", fifo_level, 0);
    check("post_rst_ignore_err", err_cnt - e0, 0);
    send_frame(16, 32'h9DEF);
    check("post_rst_frame_level", fifo_level, 1);
    check("post_rst_frame_cmd", last_cmd, 9);
    base = hs_n;
    vblank = 1'b1;
    tick(6);
    check("post_rst_write", hs_n - base, 1);
    check("post_rst_write_data", {hs_cmd[base], hs_data[base]}, 16'h9DEF);
    vblank = 1'b0;
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
